// File: rtl/ex_muldiv.sv
//------------------------------------------------------------------------------
// Module      : ex_muldiv
// Description : Iterative RV32M multiply/divide unit for the EX stage.
//               Shift-add multiply and restoring divide on operand
//               magnitudes, one bit per cycle, with a stall request that
//               freezes ID/EX until the registered result is presented.
//               Optional macro MULDIV_FAST_MUL_EN: single-cycle multiply
//               for all MUL* ops (divide stays iterative).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_md_start_i,
  input  logic [2:0]      ex_md_op_i,
  input  logic [XLEN-1:0] ex_op_a_i,
  input  logic [XLEN-1:0] ex_op_b_i,
  input  logic            fc_flush_md_i,
  output logic            ex_md_stall_o,
  output logic            ex_md_done_o,
  output logic [XLEN-1:0] ex_md_result_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  localparam logic [2:0] c_op_mul    = 3'd0;
  localparam logic [2:0] c_op_mulh   = 3'd1;
  localparam logic [2:0] c_op_mulhsu = 3'd2;
  localparam logic [2:0] c_op_mulhu  = 3'd3;
  localparam logic [2:0] c_op_div    = 3'd4;
  localparam logic [2:0] c_op_divu   = 3'd5;
  localparam logic [2:0] c_op_rem    = 3'd6;
  localparam logic [2:0] c_op_remu   = 3'd7;

  localparam logic [XLEN-1:0] c_all_ones = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] c_int_min  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*XLEN-1:0]   r_acc;   // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
  logic [XLEN-1:0]     r_opnd;  // mul: |multiplicand|; div: |divisor|
  logic [2:0]          r_op;
  logic                r_neg;
  logic                r_done;
  logic [XLEN-1:0]     r_result;

  logic                w_load;
  logic                w_imm;
  logic                w_finish;
  logic                w_stall;

  // Final result selection; shared by the iterative and single-cycle paths
  function automatic logic [XLEN-1:0] f_result(input logic [2:0]        op,
                                               input logic              neg,
                                               input logic [2*XLEN-1:0] acc);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    prod = neg ? -acc : acc;
    quo  = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op)
      c_op_mul:                          f_result = prod[XLEN-1:0];
      c_op_mulh, c_op_mulhsu, c_op_mulhu: f_result = prod[2*XLEN-1:XLEN];
      c_op_div, c_op_divu:               f_result = quo;
      default:                           f_result = rem;
    endcase
  endfunction

  // Operand signedness and magnitudes, decoded straight from ID/EX
  logic            w_sign_a;
  logic            w_sign_b;
  logic            w_neg;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;

  assign w_sign_a = ((ex_md_op_i == c_op_mulh) || (ex_md_op_i == c_op_mulhsu) ||
                     (ex_md_op_i == c_op_div)  || (ex_md_op_i == c_op_rem)) &&
                    ex_op_a_i[XLEN-1];
  assign w_sign_b = ((ex_md_op_i == c_op_mulh) || (ex_md_op_i == c_op_div) ||
                     (ex_md_op_i == c_op_rem)) && ex_op_b_i[XLEN-1];
  // Remainder follows the dividend; product and quotient follow sign_a ^ sign_b
  assign w_neg    = (ex_md_op_i == c_op_rem) ? w_sign_a : (w_sign_a ^ w_sign_b);
  assign w_abs_a  = w_sign_a ? -ex_op_a_i : ex_op_a_i;
  assign w_abs_b  = w_sign_b ? -ex_op_b_i : ex_op_b_i;

  // Divide corner cases that bypass the iteration entirely
  logic            w_special;
  logic [XLEN-1:0] w_special_res;

  always_comb begin
    w_special     = 1'b0;
    w_special_res = '0;
    if (ex_md_op_i[2]) begin
      if (ex_op_b_i == '0) begin
        w_special     = 1'b1;
        w_special_res = ex_md_op_i[1] ? ex_op_a_i : c_all_ones;
      end else if ((ex_md_op_i == c_op_div) && (ex_op_a_i == c_int_min) &&
                   (ex_op_b_i == c_all_ones)) begin
        w_special     = 1'b1;
        w_special_res = ex_op_a_i;
      end else if ((ex_md_op_i == c_op_rem) && (ex_op_a_i == c_int_min) &&
                   (ex_op_b_i == c_all_ones)) begin
        w_special     = 1'b1;
        w_special_res = '0;
      end
    end
  end

  // Single-cycle completion: divide corner cases, plus multiplies when fast mul is built in
  logic            w_imm_case;
  logic [XLEN-1:0] w_imm_res;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_prod;
  assign w_fast_prod = w_abs_a * w_abs_b;
  assign w_imm_case  = w_special || !ex_md_op_i[2];
  assign w_imm_res   = w_special ? w_special_res : f_result(ex_md_op_i, w_neg, w_fast_prod);
`else
  assign w_imm_case  = w_special;
  assign w_imm_res   = w_special_res;
`endif

  // One iteration step of the shift-add multiplier and restoring divider
  logic [XLEN:0]     w_mul_sum;
  logic [XLEN:0]     w_rem_sh;
  logic [XLEN:0]     w_diff;
  logic              w_qbit;
  logic [2*XLEN-1:0] w_acc_step;

  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_opnd};
  assign w_qbit     = !w_diff[XLEN];
  assign w_acc_step = r_op[2] ?
                      {(w_qbit ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0]), r_acc[XLEN-2:0], w_qbit} :
                      {w_mul_sum, r_acc[XLEN-1:1]};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode and stall request
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_imm       = 1'b0;
    w_finish    = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ex_md_start_i && !fc_flush_md_i) begin
          w_stall = 1'b1;
          if (w_imm_case) begin
            w_imm       = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = S_CALC;
          end
        end
      end
      S_CALC: begin
        w_stall = 1'b1;
        if (fc_flush_md_i) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == c_cnt_last) begin
          w_finish    = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (rst) w_stall = 1'b0;
  end

  // Datapath: operand latch, iteration, and registered done/result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      if (fc_flush_md_i) begin
        r_cnt <= '0;
      end else if (w_imm) begin
        r_done   <= 1'b1;
        r_result <= w_imm_res;
      end else if (w_load) begin
        r_cnt  <= '0;
        r_op   <= ex_md_op_i;
        r_neg  <= w_neg;
        r_acc  <= ex_md_op_i[2] ? {{XLEN{1'b0}}, w_abs_a} : {{XLEN{1'b0}}, w_abs_b};
        r_opnd <= ex_md_op_i[2] ? w_abs_b : w_abs_a;
      end else if (r_state == S_CALC) begin
        r_acc <= w_acc_step;
        if (w_finish) begin
          r_cnt    <= '0;
          r_done   <= 1'b1;
          r_result <= f_result(r_op, r_neg, w_acc_step);
        end else begin
          r_cnt <= r_cnt + c_cnt_one;
        end
      end
    end
  end

  assign ex_md_stall_o  = w_stall;
  assign ex_md_done_o   = r_done;
  assign ex_md_result_o = r_result;

endmodule

`default_nettype wire
